// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the full-word SPI master.
// State encoding and parameter defaults live here.
package spi_master_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_NBYTES   = 4;
  localparam int MAX_BITS     = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HOLD
  } state_e;

endpackage

// File: rtl/spi_sck_tick.sv
// Phase counter: reloaded on every state change,
// ticks in the last cycle of the loaded length.
module spi_sck_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] len_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = len_i - 8'd1;
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_fword_master.sv
// Mode-0 SPI master sending one 8..32-bit frame per start,
// with CS held low across the whole frame.
module spi_fword_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int NBYTES   = DEF_NBYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] tx_word,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_word,
  output logic        cs,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [7:0] DIV_L   = 8'(CLK_DIV);
  localparam logic [7:0] SETUP_L = 8'(CS_SETUP);
  localparam logic [7:0] HOLD_L  = 8'(CS_HOLD);
  localparam logic [4:0] LAST_BIT = 5'(8 * NBYTES - 1);

  state_e      state_q, state_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rxw_q, rxw_d;
  logic        cs_q, sck_q, busy_q, done_q;
  logic        tick, load;
  logic [7:0]  len;
  logic        accept, rise, fall, fin;

  spi_sck_tick u_tick (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .len_i  (len),
    .tick_o (tick)
  );

  // A start seen in the done cycle is not taken.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        bit_d = 5'd0;
        if (start && !done_q) state_d = SETUP;
      end
      SETUP:  if (tick) state_d = SCK_LO;
      SCK_LO: if (tick) state_d = SCK_HI;
      SCK_HI: if (tick) begin
        if (bit_q == LAST_BIT) begin
          state_d = HOLD;
        end else begin
          state_d = SCK_LO;
          bit_d   = bit_q + 5'd1;
        end
      end
      HOLD:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (state_d)
      SETUP:   len = SETUP_L;
      HOLD:    len = HOLD_L;
      default: len = DIV_L;
    endcase
  end

  assign load   = (state_d != state_q);
  assign accept = (state_q == IDLE)   && (state_d == SETUP);
  assign rise   = (state_q == SCK_LO) && (state_d == SCK_HI);
  assign fall   = (state_q == SCK_HI) && (state_d == SCK_LO);
  assign fin    = (state_q == HOLD)   && (state_d == IDLE);

  // mosi is tx_q[31]; clearing tx_q at frame end idles it low.
  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    rxw_d = rxw_q;
    if (accept) begin
      tx_d = tx_word;
      rx_d = 32'd0;
    end
    if (rise) rx_d = {rx_q[30:0], miso};
    if (fall) tx_d = {tx_q[30:0], 1'b0};
    if (fin) begin
      rxw_d = rx_q;
      tx_d  = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= 5'd0;
      tx_q    <= 32'd0;
      rx_q    <= 32'd0;
      rxw_q   <= 32'd0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxw_q   <= rxw_d;
      cs_q    <= (state_d == IDLE);
      sck_q   <= (state_d == SCK_HI);
      busy_q  <= (state_d != IDLE) || fin;
      done_q  <= fin;
    end
  end

  assign cs      = cs_q;
  assign sck     = sck_q;
  assign mosi    = tx_q[31];
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_word = rxw_q;

endmodule

// File: tb/tb_spi_fword_master.sv
// Scoreboard bench: three master configurations, checked
// at every done pulse plus a per-cycle SPI protocol monitor.
module tb_spi_fword_master;

  typedef struct {
    int          id;
    logic [31:0] rx;
    logic [31:0] mo;
    int          rises;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic [31:0] tx_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [31:0] rx_v    [3];
  logic        cs_v    [3];
  logic        sck_v   [3];
  logic        mosi_v  [3];
  logic        miso_v  [3];

  exp_t        sb [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          viol = 0;
  logic [31:0] mcap  [3] = '{32'd0, 32'd0, 32'd0};
  int          rises [3] = '{0, 0, 0};
  int          csf   [3] = '{0, 0, 0};
  int          dcnt  [3] = '{0, 0, 0};
  logic        psck  [3] = '{1'b0, 1'b0, 1'b0};
  logic        pmosi [3] = '{1'b0, 1'b0, 1'b0};
  logic        pcs   [3] = '{1'b1, 1'b1, 1'b1};

  assign miso_v[0] = mosi_v[0];
  assign miso_v[1] = 1'b1;
  assign miso_v[2] = mosi_v[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_fword_master u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .tx_word(tx_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .rx_word(rx_v[0]),
    .cs(cs_v[0]), .sck(sck_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0])
  );

  spi_fword_master #(.NBYTES(1)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .tx_word(tx_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .rx_word(rx_v[1]),
    .cs(cs_v[1]), .sck(sck_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1])
  );

  spi_fword_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .tx_word(tx_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .rx_word(rx_v[2]),
    .cs(cs_v[2]), .sck(sck_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2])
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: captures mosi at sck rises and scores each done.
  always begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (cs_v[i] && sck_v[i]) viol++;
      if (sck_v[i] && mosi_v[i] !== pmosi[i]) viol++;
      if (!cs_v[i] && !busy_v[i]) viol++;
      if (sck_v[i] && !psck[i]) begin
        mcap[i] = {mcap[i][30:0], mosi_v[i]};
        rises[i]++;
      end
      if (!cs_v[i] && pcs[i]) csf[i]++;
      if (done_v[i]) begin
        dcnt[i]++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done dut %0d: got done, required none", i);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_dut_id", 32'(i), 32'(e.id));
          check("rx_word", rx_v[i], e.rx);
          check("mosi_at_rises", mcap[i], e.mo);
          check("sck_rises", 32'(rises[i]), 32'(e.rises));
          check("cs_windows", 32'(csf[i]), 32'd1);
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_at_done", 32'(busy_v[i]), 32'd1);
        end
        mcap[i]  = 32'd0;
        rises[i] = 0;
        csf[i]   = 0;
      end
      if (!rst) begin
        mcap[i]  = 32'd0;
        rises[i] = 0;
        csf[i]   = 0;
      end
      psck[i]  = sck_v[i];
      pmosi[i] = mosi_v[i];
      pcs[i]   = cs_v[i];
    end
  end

  task automatic issue(input int id, input logic [31:0] tx,
                       input logic [31:0] erx, input logic [31:0] emo,
                       input int nr, input int lat);
    tx_v[id]    = tx;
    start_v[id] = 1'b1;
    sb.push_back('{id, erx, emo, nr, cyc + lat});
    @(negedge clk);
    start_v[id] = 1'b0;
    check("busy_cs_after_start", 32'({busy_v[id], cs_v[id]}), 32'b10);
  endtask

  task automatic wait_done(input int id, input int budget);
    int n;
    n = 0;
    while (!done_v[id] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[id]) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout dut %0d: actual no done, required done", id);
    end
  endtask

  initial begin
    int d;
    int n;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      tx_v[i]    = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_outs",
            32'({cs_v[i], sck_v[i], mosi_v[i], busy_v[i], done_v[i]}),
            32'b10000);
      check("reset_rx", rx_v[i], 32'd0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Default 32-bit loopback frame
    issue(0, 32'hC5B0_1A28, 32'hC5B0_1A28, 32'hC5B0_1A28, 32, 261);
    wait_done(0, 300);
    @(negedge clk);

    // One byte, miso tied high
    issue(1, 32'hA512_3456, 32'h0000_00FF, 32'h0000_00A5, 8, 69);
    wait_done(1, 100);
    @(negedge clk);

    // Second start mid-frame is ignored
    d = dcnt[0];
    issue(0, 32'h8001_FFFE, 32'h8001_FFFE, 32'h8001_FFFE, 32, 261);
    repeat (48) @(negedge clk);
    tx_v[0]    = 32'hDEAD_BEEF;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 300);
    repeat (300) @(negedge clk);
    check("single_done", 32'(dcnt[0] - d), 32'd1);
    check("idle_after_frame", 32'({busy_v[0], cs_v[0]}), 32'b01);

    // Reset during bit 13
    issue(0, 32'h0F1E_2D3C, 32'h0F1E_2D3C, 32'h0F1E_2D3C, 32, 261);
    n = 0;
    while (rises[0] < 13 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit13", 32'(rises[0]), 32'd13);
    #2 rst = 1'b0;
    #1;
    check("abort_outs",
          32'({cs_v[0], sck_v[0], busy_v[0], done_v[0]}), 32'b1000);
    check("abort_rx", rx_v[0], 32'd0);
    sb.delete();
    d = dcnt[0];
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("no_done_after_abort", 32'(dcnt[0] - d), 32'd0);
    check("no_resume", 32'({cs_v[0], busy_v[0]}), 32'b10);
    issue(0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32, 261);
    wait_done(0, 300);
    @(negedge clk);

    // Fast config; start in the done cycle is lost
    issue(2, 32'h3C96_E10F, 32'h3C96_E10F, 32'h3C96_E10F, 32, 67);
    wait_done(2, 100);
    tx_v[2]    = 32'hFFFF_FFFF;
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    d = dcnt[2];
    repeat (100) @(negedge clk);
    check("lost_start", 32'(dcnt[2] - d), 32'd0);
    check("lost_start_idle", 32'(busy_v[2]), 32'd0);

    // Start held through done is taken one cycle later
    issue(2, 32'h5A5A_C3C3, 32'h5A5A_C3C3, 32'h5A5A_C3C3, 32, 67);
    wait_done(2, 100);
    tx_v[2]    = 32'h0F0F_A55A;
    start_v[2] = 1'b1;
    sb.push_back('{2, 32'h0F0F_A55A, 32'h0F0F_A55A, 32, cyc + 1 + 67});
    @(negedge clk);
    @(negedge clk);
    start_v[2] = 1'b0;
    wait_done(2, 100);
    repeat (3) @(negedge clk);

    check("protocol_violations", 32'(viol), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
